// File: rtl/cp_seq_pkg.sv
// Shared types and widths for the charge-pump sequencer and its lock detector.
package cp_seq_pkg;

  localparam int unsigned CNT_W   = 8;
  localparam int unsigned MINPW_W = 4;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [2:0] {
    S_OFF,
    S_SETTLE,
    S_IDLE,
    S_PUMP_UP,
    S_PUMP_DN,
    S_OVERLAP
  } state_t;

endpackage

// File: rtl/cp_seq_lock_det.sv
// Lock detector: counts consecutive in-tolerance pulse lengths and raises locked
// once the saturating run count reaches the required number.
module cp_seq_lock_det
  import cp_seq_pkg::*;
(
  input  logic             clk,
  input  logic             resetb,
  input  logic             clear,
  input  logic             pulse_valid,
  input  logic [CNT_W-1:0] pulse_len,
  input  logic [CNT_W-1:0] lock_tol,
  input  logic [CNT_W-1:0] lock_cnt,
  output logic             locked
);

  logic [CNT_W-1:0] run_cnt;
  logic [CNT_W-1:0] run_inc;
  logic [CNT_W-1:0] need;

  always_comb begin
    run_inc = (run_cnt == '1) ? run_cnt : run_cnt + CNT_ONE;
    need    = (lock_cnt == '0) ? CNT_ONE : lock_cnt;
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      run_cnt <= '0;
      locked  <= 1'b0;
    end else if (clear) begin
      run_cnt <= '0;
      locked  <= 1'b0;
    end else if (pulse_valid) begin
      if (pulse_len <= lock_tol) begin
        run_cnt <= run_inc;
        locked  <= (run_inc >= need);
      end else begin
        run_cnt <= '0;
        locked  <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/cp_sequencer.sv
// Charge-pump sequencer: bias settle, up/down pulse generation with timeout and
// slip detection, and an overlap phase. Define CP_SEQ_DEADZONE_EN to drive
// up=down=1 for cfg_min_pw cycles in the overlap phase.
module cp_sequencer
  import cp_seq_pkg::*;
(
  input  logic               clk,
  input  logic               resetb,
  input  logic               enable,
  input  logic               ref_edge,
  input  logic               fb_edge,
  input  logic [CNT_W-1:0]   cfg_settle,
  input  logic [CNT_W-1:0]   cfg_max_pw,
  input  logic [MINPW_W-1:0] cfg_min_pw,
  input  logic [CNT_W-1:0]   cfg_lock_tol,
  input  logic [CNT_W-1:0]   cfg_lock_cnt,
  output logic               up,
  output logic               down,
  output logic               bias_en,
  output logic               locked,
  output logic               slip
);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] max_pw_q, max_pw_nxt;
  logic [CNT_W-1:0] tol_q, tol_nxt;
  logic [CNT_W-1:0] lcnt_q, lcnt_nxt;
  logic             drive_q, drive_nxt;
  logic             up_nxt, down_nxt, bias_nxt, slip_nxt;
  logic             pulse_valid, lock_clear;
  logic [CNT_W-1:0] pulse_len;
  logic [CNT_W-1:0] ov_load;
  logic             ov_drive;

`ifdef CP_SEQ_DEADZONE_EN
  always_comb begin
    ov_load  = (cfg_min_pw == '0) ? CNT_ONE : {{(CNT_W-MINPW_W){1'b0}}, cfg_min_pw};
    ov_drive = (cfg_min_pw != '0);
  end
`else
  logic unused_min_pw;
  assign unused_min_pw = ^cfg_min_pw;
  always_comb begin
    ov_load  = CNT_ONE;
    ov_drive = 1'b0;
  end
`endif

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    max_pw_nxt  = max_pw_q;
    tol_nxt     = tol_q;
    lcnt_nxt    = lcnt_q;
    drive_nxt   = drive_q;
    slip_nxt    = 1'b0;
    pulse_valid = 1'b0;
    pulse_len   = cnt;
    lock_clear  = 1'b0;

    if (!enable) begin
      state_nxt  = S_OFF;
      cnt_nxt    = '0;
      drive_nxt  = 1'b0;
      lock_clear = 1'b1;
    end else begin
      case (state)
        S_OFF: begin
          state_nxt = S_SETTLE;
          cnt_nxt   = cfg_settle;
          tol_nxt   = cfg_lock_tol;
          lcnt_nxt  = cfg_lock_cnt;
        end
        S_SETTLE: begin
          if (cnt <= CNT_ONE) begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt - CNT_ONE;
          end
        end
        S_IDLE: begin
          max_pw_nxt = (cfg_max_pw == '0) ? CNT_ONE : cfg_max_pw;
          if (ref_edge && fb_edge) begin
            pulse_valid = 1'b1;
            pulse_len   = '0;
            state_nxt   = S_OVERLAP;
            cnt_nxt     = ov_load;
            drive_nxt   = ov_drive;
          end else if (ref_edge) begin
            state_nxt = S_PUMP_UP;
            cnt_nxt   = CNT_ONE;
          end else if (fb_edge) begin
            state_nxt = S_PUMP_DN;
            cnt_nxt   = CNT_ONE;
          end
        end
        S_PUMP_UP, S_PUMP_DN: begin
          // The opposite edge ends the pulse; a repeat of the starting edge
          // is a slip that keeps counting toward the timeout.
          cnt_nxt = cnt + CNT_ONE;
          if ((state == S_PUMP_UP) ? fb_edge : ref_edge) begin
            pulse_valid = 1'b1;
            state_nxt   = S_OVERLAP;
            cnt_nxt     = ov_load;
            drive_nxt   = ov_drive;
          end else begin
            if ((state == S_PUMP_UP) ? ref_edge : fb_edge) begin
              slip_nxt   = 1'b1;
              lock_clear = 1'b1;
            end
            if (cnt >= max_pw_q) begin
              lock_clear = 1'b1;
              state_nxt  = S_IDLE;
              cnt_nxt    = '0;
            end
          end
        end
        S_OVERLAP: begin
          if (cnt <= CNT_ONE) begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
            drive_nxt = 1'b0;
          end else begin
            cnt_nxt = cnt - CNT_ONE;
          end
        end
        default: begin
          state_nxt = S_OFF;
          cnt_nxt   = '0;
        end
      endcase
    end

    up_nxt   = (state_nxt == S_PUMP_UP) || ((state_nxt == S_OVERLAP) && drive_nxt);
    down_nxt = (state_nxt == S_PUMP_DN) || ((state_nxt == S_OVERLAP) && drive_nxt);
    bias_nxt = (state_nxt != S_OFF);
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state    <= S_OFF;
      cnt      <= '0;
      max_pw_q <= '0;
      tol_q    <= '0;
      lcnt_q   <= '0;
      drive_q  <= 1'b0;
      up       <= 1'b0;
      down     <= 1'b0;
      bias_en  <= 1'b0;
      slip     <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      max_pw_q <= max_pw_nxt;
      tol_q    <= tol_nxt;
      lcnt_q   <= lcnt_nxt;
      drive_q  <= drive_nxt;
      up       <= up_nxt;
      down     <= down_nxt;
      bias_en  <= bias_nxt;
      slip     <= slip_nxt;
    end
  end

  cp_seq_lock_det u_lock_det (
    .clk         (clk),
    .resetb      (resetb),
    .clear       (lock_clear),
    .pulse_valid (pulse_valid),
    .pulse_len   (pulse_len),
    .lock_tol    (tol_q),
    .lock_cnt    (lcnt_q),
    .locked      (locked)
  );

endmodule

// File: doc/cp_sequencer.md
CP_SEQUENCER -- requirements
Module: cp_sequencer

Interface
REQ-001 SHALL have port clk, input, 1: single clock; all state changes occur on its rising edge.
REQ-002 SHALL have port resetb, input, 1: asynchronous, active-low reset.
REQ-003 SHALL have port enable, input, 1: 1 = run sequencer, 0 = shut down the charge pump.
REQ-004 SHALL have port ref_edge, input, 1: one-cycle pulse per reference edge, already synchronized to clk.
REQ-005 SHALL have port fb_edge, input, 1: one-cycle pulse per divided-feedback edge, already synchronized to clk.
REQ-006 SHALL have port cfg_settle, input, 8: bias settle time in cycles.
REQ-007 SHALL have port cfg_max_pw, input, 8: maximum up/down pulse length in cycles; 0 is treated as 1.
REQ-008 SHALL have port cfg_min_pw, input, 4: dead-zone overlap length in cycles.
REQ-009 SHALL have port cfg_lock_tol, input, 8: largest pulse length counted as in-lock.
REQ-010 SHALL have port cfg_lock_cnt, input, 8: consecutive in-tolerance comparisons needed to declare lock; 0 is treated as 1.
REQ-011 SHALL have ports up and down, output, 1 each: charge-pump drive, registered.
REQ-012 SHALL have port bias_en, output, 1: enables the charge-pump vbias, registered.
REQ-013 SHALL have port locked, output, 1: lock indication, registered.
REQ-014 SHALL have port slip, output, 1: one-cycle pulse on a cycle slip.

Function
REQ-015 SHALL implement the states OFF, SETTLE, IDLE, PUMP_UP, PUMP_DN and OVERLAP.
REQ-016 SHALL, in OFF with enable=1, go to SETTLE and set bias_en=1 on the next cycle.
REQ-017 SHALL stay in SETTLE for exactly cfg_settle cycles, then go to IDLE; edges arriving during SETTLE SHALL be ignored.
REQ-018 SHALL, in IDLE on ref_edge only at cycle N, enter PUMP_UP with up=1 from N+1.
REQ-019 SHALL, in IDLE on fb_edge only, enter PUMP_DN with down=1 from the next cycle.
REQ-020 SHALL, in IDLE on ref_edge and fb_edge in the same cycle, record a pulse length of 0 and go to OVERLAP.
REQ-021 SHALL count the pulse length from 1 while in PUMP_UP or PUMP_DN.
REQ-022 SHALL end PUMP_UP on fb_edge (or PUMP_DN on ref_edge) and record the count at that cycle as the pulse length.
REQ-023 SHALL, when the count reaches cfg_max_pw, end the pulse and record it as out of tolerance.
REQ-024 SHALL, on a repeated ref_edge in PUMP_UP (or fb_edge in PUMP_DN), pulse slip for one cycle and continue the pulse without restarting the count.
REQ-025 SHALL go from OVERLAP back to IDLE, with up=down=0, after the OVERLAP duration defined in REQ-039/REQ-040.
REQ-026 SHALL never assert up and down together outside OVERLAP.
REQ-027 SHALL treat a recorded pulse length <= cfg_lock_tol as in tolerance and increment a saturating consecutive counter.
REQ-028 SHALL set locked when the consecutive counter reaches cfg_lock_cnt.
REQ-029 SHALL clear the counter and locked on any out-of-tolerance pulse (including a max_pw timeout) or on any slip.
REQ-030 SHALL, when enable=0 in any state, on the next cycle go to OFF with up=down=bias_en=locked=0 and the counter cleared.
REQ-031 SHALL have enable=0 take priority over simultaneous edges.
REQ-032 SHALL capture cfg_* values when their state is entered; changes mid-state take effect at the next entry.

Reset
REQ-033 SHALL, on resetb=0, immediately go to OFF with up=down=bias_en=locked=slip=0 and all counters at 0.
REQ-034 SHALL, after resetb is released, leave OFF no earlier than the first rising edge of clk with enable=1.

Configuration
REQ-035 SHALL use the macro CP_SEQ_DEADZONE_EN.
REQ-036 SHALL, with CP_SEQ_DEADZONE_EN defined, at pulse end drive up=down=1 for cfg_min_pw cycles in OVERLAP.
REQ-037 SHALL, with CP_SEQ_DEADZONE_EN defined and cfg_min_pw=0, hold OVERLAP for one cycle with up=down=0.
REQ-038 SHALL, with CP_SEQ_DEADZONE_EN defined, include the simultaneous-edge case of REQ-020 in this overlap behaviour.
REQ-039 SHALL, without CP_SEQ_DEADZONE_EN, hold OVERLAP for exactly one cycle with up=down=0.
REQ-040 SHALL, without CP_SEQ_DEADZONE_EN, ignore cfg_min_pw.

Structure
REQ-041 SHALL place the state enum, the counter width constant (8) and the min_pw width constant (4) in the shared package cp_seq_pkg.
REQ-042 SHALL implement the lock counter, tolerance compare and locked flag in the sub-module cp_seq_lock_det, fed by a one-cycle pulse-valid strobe plus the recorded pulse length.

Verification
REQ-043 SHALL check: enable=1, cfg_settle=4 -> bias_en=1 after 1 cycle, IDLE reached after 5 cycles, and ref_edge during SETTLE gives no up.
REQ-044 SHALL check: ref_edge at N, fb_edge at N+3, deadzone on, cfg_min_pw=2 -> up high N+1..N+3, up=down=1 N+4..N+5, both low at N+6.
REQ-045 SHALL check: cfg_max_pw=10, ref_edge with no fb_edge -> up high exactly 10 cycles, and locked cleared.
REQ-046 SHALL check: cfg_lock_tol=2, cfg_lock_cnt=3, three pulses of length 1 then one of length 5 -> locked rises after the third pulse and falls after the fourth.
REQ-047 SHALL check: two ref_edge pulses while in PUMP_UP -> slip pulses once per repeat, the count continues, and locked=0.
REQ-048 SHALL check: enable dropped in PUMP_DN (and separately resetb asserted in OVERLAP) -> all outputs 0 (next cycle, or immediately for reset), state OFF.
